// File: rtl/dm_arbiter_if.sv
// dm_arbiter bus bundle: MEM-stage port, debug/loader port and DM macro port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              cpu_re;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              dbg_valid;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [31:0]       dbg_wdata;
    logic              dbg_ready;
    logic              dbg_rvalid;
    logic [31:0]       dbg_rdata;
    logic              dbg_lock;
    logic              dbg_locked;
    logic [ADDR_W-1:0] dm_a;
    logic [31:0]       dm_d;
    logic              dm_we;
    logic [31:0]       dm_spo;

    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  dm_spo,
        output cpu_rdata, cpu_stall,
        output dbg_ready, dbg_rvalid, dbg_rdata, dbg_locked,
        output dm_a, dm_d, dm_we
    );

    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output dm_spo,
        input  cpu_rdata, cpu_stall,
        input  dbg_ready, dbg_rvalid, dbg_rdata, dbg_locked,
        input  dm_a, dm_d, dm_we
    );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single DM port between the MEM stage and debug/loader.
// CPU has priority; a wait counter force-grants debug; LOCK gives loader ownership.
module dm_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);
    typedef enum logic {
        S_CPU  = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_WAIT);

    state_t      r_state;
    logic [3:0]  r_wait;
    logic        r_locked;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic              w_cpu_act;
    logic              w_dbg_gnt;
    logic              w_xfer;
    logic              w_rd_acc;
    logic [ADDR_W-1:0] w_cpu_idx;
    logic              w_unused_addr;

    assign w_cpu_act     = bus.cpu_re | bus.cpu_we;
    assign w_cpu_idx     = bus.cpu_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{bus.cpu_addr[31:ADDR_W+2], bus.cpu_addr[1:0]};

    // Debug wins when locked, when the CPU is idle, or once it has waited long enough.
    assign w_dbg_gnt = (r_state == S_LOCK)
                     | (bus.dbg_valid & (~w_cpu_act | (r_wait == LP_MAX)));

    assign w_xfer   = bus.dbg_valid & w_dbg_gnt;
    assign w_rd_acc = w_xfer & ~bus.dbg_we;

    // Steer the DM port and build the per-requester responses from the grant.
    always_comb begin
        bus.dm_a      = w_cpu_idx;
        bus.dm_d      = bus.cpu_wdata;
        bus.dm_we     = 1'b0;
        bus.cpu_rdata = '0;
        bus.cpu_stall = 1'b0;
        bus.dbg_ready = 1'b0;
        if (w_dbg_gnt) begin
            bus.dm_a      = bus.dbg_addr;
            bus.dm_d      = bus.dbg_wdata;
            bus.dm_we     = bus.dbg_valid & bus.dbg_we;
            bus.dbg_ready = 1'b1;
            bus.cpu_stall = w_cpu_act;
        end else begin
            bus.dm_we = bus.cpu_we;
            if (bus.cpu_re & ~bus.cpu_we)
                bus.cpu_rdata = bus.dm_spo;
        end
        // Reset must never let a write or a handshake slip through.
        if (rst) begin
            bus.dm_we     = 1'b0;
            bus.cpu_stall = 1'b0;
            bus.dbg_ready = 1'b0;
        end
    end

    assign bus.dbg_locked = r_locked;
    assign bus.dbg_rvalid = r_rvalid;
    assign bus.dbg_rdata  = r_rdata;

    // Ownership FSM: lock follows dbg_lock one edge later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_CPU;
            r_locked <= 1'b0;
        end else begin
            unique case (r_state)
                S_CPU: begin
                    if (bus.dbg_lock) begin
                        r_state  <= S_LOCK;
                        r_locked <= 1'b1;
                    end
                end
                S_LOCK: begin
                    if (!bus.dbg_lock) begin
                        r_state  <= S_CPU;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_CPU;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter and registered debug read return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait   <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (!bus.dbg_valid || w_xfer)
                r_wait <= '0;
            else if (w_cpu_act && r_wait != LP_MAX)
                r_wait <= r_wait + 4'd1;
            r_rvalid <= w_rd_acc;
            if (w_rd_acc)
                r_rdata <= bus.dm_spo;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: DM macro model, directed scenarios and random traffic.
// Expected responses are queued by the driver and compared by a monitor.
module tb_dm_arbiter;
    localparam int AW = 10;
    localparam int MW = 4;

    typedef struct {
        logic          re;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic          dv;
        logic          dwe;
        logic [AW-1:0] daddr;
        logic [31:0]   dwdata;
        logic          lock;
    } stim_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          we;
        logic [31:0]   crd;
        logic          stall;
        logic          rdy;
        logic          rv;
        logic [31:0]   rd;
        logic          lk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    dm_arbiter_if #(.ADDR_W(AW)) bus ();

    dm_arbiter #(.ADDR_W(AW), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] dm_mem  [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    assign bus.dm_spo = dm_mem[bus.dm_a];
    always @(posedge clk) if (bus.dm_we) dm_mem[bus.dm_a] <= bus.dm_d;

    exp_t q[$];
    bit          m_lock = 0;
    int          m_wait = 0;
    bit          m_rv   = 0;
    logic [31:0] m_rd   = '0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, act, exp, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.re = 0; s.we = 0; s.addr = '0; s.wdata = '0;
        s.dv = 0; s.dwe = 0; s.daddr = '0; s.dwdata = '0;
        s.lock = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.cpu_re    = s.re;
        bus.cpu_we    = s.we;
        bus.cpu_addr  = s.addr;
        bus.cpu_wdata = s.wdata;
        bus.dbg_valid = s.dv;
        bus.dbg_we    = s.dwe;
        bus.dbg_addr  = s.daddr;
        bus.dbg_wdata = s.dwdata;
        bus.dbg_lock  = s.lock;
    endtask

    // One clock cycle: drive, predict, queue, then advance the reference state.
    task automatic step(input stim_t s);
        exp_t e;
        bit act, g;
        logic [AW-1:0] ca;
        @(negedge clk);
        drive(s);
        act = s.re | s.we;
        ca  = s.addr[AW+1:2];
        g   = m_lock || (s.dv && (!act || m_wait == MW));
        if (g) begin
            e.a = s.daddr; e.d = s.dwdata; e.we = s.dv & s.dwe;
            e.rdy = 1; e.stall = act; e.crd = '0;
        end else begin
            e.a = ca; e.d = s.wdata; e.we = s.we;
            e.rdy = 0; e.stall = 0;
            e.crd = (s.re && !s.we) ? ref_mem[ca] : 32'h0;
        end
        e.rv = m_rv; e.rd = m_rd; e.lk = m_lock;
        q.push_back(e);
        @(posedge clk);
        if (g && s.dv && !s.dwe) begin
            m_rv = 1; m_rd = ref_mem[s.daddr];
        end else begin
            m_rv = 0;
        end
        if (e.we) ref_mem[e.a] = e.d;
        if (!s.dv || g) m_wait = 0;
        else if (act && m_wait < MW) m_wait++;
        m_lock = s.lock;
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("dm_a",       32'(bus.dm_a),   32'(e.a));
                chk("dm_d",       bus.dm_d,        e.d);
                chk("dm_we",      32'(bus.dm_we),  32'(e.we));
                chk("cpu_rdata",  bus.cpu_rdata,   e.crd);
                chk("cpu_stall",  32'(bus.cpu_stall), 32'(e.stall));
                chk("dbg_ready",  32'(bus.dbg_ready), 32'(e.rdy));
                chk("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e.rv));
                chk("dbg_rdata",  bus.dbg_rdata,   e.rd);
                chk("dbg_locked", 32'(bus.dbg_locked), 32'(e.lk));
            end
        end
    end

    initial begin
        stim_t s;
        bit lk;
        int n;
        for (int i = 0; i < (1<<AW); i++) begin
            dm_mem[i]  = '0;
            ref_mem[i] = '0;
        end
        drive(idle());
        repeat (2) @(negedge clk);
        #2;
        chk("rst_locked", 32'(bus.dbg_locked), 32'd0);
        chk("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("rst_rdata",  bus.dbg_rdata,       32'd0);
        chk("rst_dm_we",  32'(bus.dm_we),      32'd0);
        chk("rst_stall",  32'(bus.cpu_stall),  32'd0);
        chk("rst_ready",  32'(bus.dbg_ready),  32'd0);
        rst = 1'b0;

        // CPU store then load of the same word.
        s = idle(); s.we = 1; s.addr = 32'h10; s.wdata = 32'hDEADBEEF; step(s);
        s = idle(); s.re = 1; s.addr = 32'h10; step(s);

        // Debug read while the CPU is idle.
        s = idle(); s.dv = 1; s.daddr = 10'd4; step(s);
        step(idle());
        step(idle());

        // Starvation: CPU loads every cycle, debug held.
        for (int i = 0; i < 6; i++) begin
            s = idle(); s.re = 1; s.addr = 32'(i) << 2;
            s.dv = 1; s.daddr = 10'd4;
            step(s);
        end
        step(idle());

        // Lock with a CPU store pending, three debug writes, then unlock.
        s = idle(); s.we = 1; s.addr = 32'h20; s.wdata = 32'h1234; s.lock = 1; step(s);
        for (int i = 1; i <= 3; i++) begin
            s = idle(); s.re = 1; s.addr = 32'h20; s.lock = 1;
            s.dv = 1; s.dwe = 1; s.daddr = 10'(i); s.dwdata = 32'hA000 + 32'(i);
            step(s);
        end
        s = idle(); s.re = 1; s.addr = 32'h4; step(s);
        s = idle(); s.re = 1; s.addr = 32'h4; step(s);
        s = idle(); s.re = 1; s.addr = 32'h8; step(s);

        // Store and load asserted together behaves as a store.
        s = idle(); s.re = 1; s.we = 1; s.addr = 32'h30; s.wdata = 32'h5; step(s);
        s = idle(); s.re = 1; s.addr = 32'hFFFF_F033; step(s);

        // Random traffic.
        lk = 0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(19) == 0) lk = ~lk;
            s.re     = ($urandom_range(2) == 0);
            s.we     = ($urandom_range(3) == 0);
            s.addr   = $urandom;
            s.addr[AW+1:2] = 10'($urandom_range(15));
            s.wdata  = $urandom;
            s.dv     = ($urandom_range(1) == 0);
            s.dwe    = ($urandom_range(1) == 0);
            s.daddr  = 10'($urandom_range(15));
            s.dwdata = $urandom;
            s.lock   = lk;
            step(s);
        end

        // Reset mid-cycle while locked with a read result pending.
        s = idle(); s.lock = 1; step(s);
        s = idle(); s.lock = 1; s.dv = 1; s.daddr = 10'd4; step(s);
        @(negedge clk);
        s = idle(); s.lock = 1; s.re = 1; drive(s);
        #2;
        chk("pre_locked", 32'(bus.dbg_locked), 32'd1);
        chk("pre_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        chk("pre_stall",  32'(bus.cpu_stall),  32'd1);
        rst = 1'b1;
        #1;
        chk("ar_locked", 32'(bus.dbg_locked), 32'd0);
        chk("ar_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        chk("ar_dm_we",  32'(bus.dm_we),      32'd0);
        chk("ar_stall",  32'(bus.cpu_stall),  32'd0);
        drive(idle());
        @(negedge clk);
        rst = 1'b0;
        m_lock = 0; m_wait = 0; m_rv = 0; m_rd = '0;

        s = idle(); s.dv = 1; s.daddr = 10'd1; step(s);
        s = idle(); s.re = 1; s.addr = 32'h8; step(s);
        step(idle());

        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Owns the single port of the data-memory macro DM (async-read, sync-write, word-addressed) and shares it between two requesters: the pipeline MEM stage and the debug/loader port.
- MEM stage has priority, but an anti-starvation counter guarantees debug access; a lock mode gives the loader exclusive ownership while the CPU is stalled.
- Sits between the MEM stage and DM and produces the CPU stall request consumed by the hazard unit.

Parameters:
- ADDR_W, 10, DM word-address width.
- MAX_WAIT, 4, cycles a pending debug request may be blocked by the CPU before it is force-granted; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_re  in  1  MEM-stage load
- cpu_we  in  1  MEM-stage store
- cpu_addr  in  32  byte address from ALU; word index = cpu_addr[ADDR_W+1:2]
- cpu_wdata  in  32  store data, already forwarded
- cpu_rdata  out  32  load data; 0 when the load is not serviced this cycle
- cpu_stall  out  1  CPU access not serviced this cycle; pipeline must hold
- dbg_valid  in  1  debug request valid
- dbg_we  in  1  debug write (1) / read (0)
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  32  debug write data
- dbg_ready  out  1  request accepted this cycle (valid&ready = transfer)
- dbg_rvalid  out  1  registered; high exactly one cycle after an accepted read
- dbg_rdata  out  32  registered read data, held until the next accepted read
- dbg_lock  in  1  loader requests exclusive ownership
- dbg_locked  out  1  registered; arbiter is in LOCK
- dm_a  out  ADDR_W  to DM address
- dm_d  out  32  to DM write data
- dm_we  out  1  to DM write enable

Behaviour:
- Reset values: state=CPU, wait_cnt=0, dbg_rvalid=0, dbg_rdata=0, dbg_locked=0.
- Combinational outputs driven from reset state: dm_we=0, cpu_stall=0, dbg_ready=0.
- cpu_act = cpu_re|cpu_we. If both cpu_re and cpu_we are high, the access is treated as a store and cpu_rdata=0.
- Grant (combinational, from the current state):
  - CPU state: if dbg_valid & (!cpu_act | wait_cnt==MAX_WAIT), debug is granted; otherwise the CPU is granted.
  - LOCK state: debug is always granted.
- Debug grant:
  - dm_a=dbg_addr, dm_d=dbg_wdata, dm_we=dbg_valid&dbg_we, dbg_ready=1.
  - cpu_stall=cpu_act; cpu_rdata=0.
- CPU grant:
  - dm_a=cpu word index, dm_d=cpu_wdata, dm_we=cpu_we.
  - cpu_rdata = cpu_re&!cpu_we ? DM spo : 0; cpu_stall=0; dbg_ready=0.
- Idle: with no CPU access and no debug request, the CPU is granted and dm_we=0.
- wait_cnt:
  - Increments when dbg_valid & cpu_act & CPU granted, saturating at MAX_WAIT.
  - Clears on any debug transfer or when dbg_valid=0.
- State transitions:
  - CPU -> LOCK when dbg_lock=1.
  - LOCK -> CPU when dbg_lock=0.
  - Transition happens on the clock edge, so lock takes effect the cycle after dbg_lock rises. In that cycle, normal arbitration still applies.
- dbg_locked = (state==LOCK).
- In LOCK: cpu_stall=cpu_act continuously; dbg_ready=1 whether or not dbg_valid is high.
- Read return: on an accepted debug read, dbg_rdata <= DM spo and dbg_rvalid <= 1 at the next edge; otherwise dbg_rvalid <= 0.
- Same-cycle hazard: a debug write and a stalled CPU load to the same address are safe. The CPU re-issues the load next cycle and sees the new data; no bypass is needed.
- Reset mid-operation: async reset clears all state immediately and aborts any in-flight debug read (dbg_rvalid=0). A write is never half-done, because DM writes only on the clock edge.
- Address width: cpu_addr bits above ADDR_W+1 and bits [1:0] are ignored; there is no alignment trap.

Test Plan:
- Reset: assert rst mid-cycle with state=LOCK and dbg_rvalid=1 -> immediately dbg_locked=0, dbg_rvalid=0, dm_we=0, cpu_stall=0.
- CPU only: cpu_we=1, addr=0x10, wdata=0xDEADBEEF; next cycle cpu_re=1, addr=0x10 -> dm_a=4, same-cycle cpu_rdata=0xDEADBEEF, cpu_stall=0 throughout.
- Idle debug read: CPU idle, dbg_valid=1, we=0, addr=4 -> dbg_ready=1 that cycle; next cycle dbg_rvalid=1, dbg_rdata=0xDEADBEEF; the cycle after, dbg_rvalid=0.
- Starvation (MAX_WAIT=4): CPU issues loads every cycle, dbg_valid held -> dbg_ready=0 for 4 cycles; 5th cycle dbg_ready=1, cpu_stall=1, cpu_rdata=0; 6th cycle CPU serviced, wait_cnt=0.
- Lock: raise dbg_lock with a CPU store pending -> that cycle the store is written; next cycle dbg_locked=1 and cpu_stall=1. Perform 3 debug writes, drop dbg_lock -> after the next edge dbg_locked=0 and the CPU access is granted.
- Store+load conflict: cpu_re=cpu_we=1, wdata=0x5 -> dm_we=1, cpu_rdata=0, memory word updated to 0x5.
